// File: rtl/io_bridge_pkg.sv
// Shared constants and helpers for the pad scan bridge.
package io_bridge_pkg;

  localparam int ERR_OVERRUN  = 0;
  localparam int ERR_UNDERRUN = 1;

  function automatic int words(input int width, input int pin_w);
    return (width + pin_w - 1) / pin_w;
  endfunction

endpackage

// File: rtl/io_word_counter.sv
// Saturating word counter: clear/set pick the base value, then one inc or dec step applies.
module io_word_counter #(
  parameter int MAX = 5,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         set,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] base;
  logic [W-1:0] cnt_nxt;

  // clr with inc yields 1: a word shifted on the clearing edge still counts
  always_comb begin
    base    = clr ? '0 : (set ? MAX_V : cnt);
    cnt_nxt = base;
    if (inc && (base != MAX_V)) begin
      cnt_nxt = base + W'(1);
    end else if (dec && (base != '0)) begin
      cnt_nxt = base - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/io_scan_bridge.sv
// Word-serial bridge between a narrow pad bus and wide core input/output vectors.
module io_scan_bridge
  import io_bridge_pkg::*;
#(
  parameter int PIN_W      = 32,
  parameter int IN_W       = 134,
  parameter int OUT_W      = 148,
  parameter int AUTO_LATCH = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic             shift,
  input  logic             latch,
  input  logic [PIN_W-1:0] pin_in,
  output logic [PIN_W-1:0] pin_out,
  output logic [PIN_W-1:0] pin_oeb,
  output logic [IN_W-1:0]  core_in,
  input  logic [OUT_W-1:0] core_out,
  output logic             in_full,
  output logic             out_empty,
  output logic             latch_done,
  output logic [1:0]       err
);

  localparam int IN_WORDS  = words(IN_W, PIN_W);
  localparam int OUT_WORDS = words(OUT_W, PIN_W);
  localparam int IN_RW     = IN_WORDS * PIN_W;
  localparam int OUT_RW    = OUT_WORDS * PIN_W;
  localparam int IN_CW     = $clog2(IN_WORDS + 1);
  localparam int OUT_CW    = $clog2(OUT_WORDS + 1);

  logic [IN_RW-1:0]  in_reg;
  logic [IN_RW-1:0]  in_shifted;
  logic [IN_RW-1:0]  pin_ext;
  logic [OUT_RW-1:0] out_reg;
  logic [OUT_RW-1:0] out_load;
  logic [IN_CW-1:0]  in_cnt;
  logic [OUT_CW-1:0] out_cnt;
  logic              load_shift;
  logic              unload_shift;
  logic              auto_fire;
  logic              overrun;
  logic              underrun;

  assign load_shift   = shift & we;
  assign unload_shift = shift & ~we;
  assign auto_fire    = (AUTO_LATCH != 0) && load_shift && (in_cnt == IN_CW'(IN_WORDS - 1));
  assign overrun      = load_shift && in_full && (AUTO_LATCH == 0);
  assign underrun     = unload_shift && out_empty;

  always_comb begin
    pin_ext              = '0;
    pin_ext[PIN_W-1:0]   = pin_in;
    in_shifted           = (in_reg << PIN_W) | pin_ext;
    out_load             = '0;
    out_load[OUT_W-1:0]  = core_out;
  end

  // Auto-latch takes the post-shift image; an explicit latch takes the pre-shift image.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_reg     <= '0;
      out_reg    <= '0;
      core_in    <= '0;
      latch_done <= 1'b0;
      err        <= '0;
    end else begin
      if (load_shift) begin
        in_reg <= in_shifted;
      end
      if (auto_fire) begin
        core_in <= in_shifted[IN_W-1:0];
      end else if (latch) begin
        core_in <= in_reg[IN_W-1:0];
      end
      if (latch) begin
        out_reg <= out_load;
      end else if (unload_shift) begin
        out_reg <= out_reg >> PIN_W;
      end
      latch_done        <= latch | auto_fire;
      err[ERR_OVERRUN]  <= overrun  | (err[ERR_OVERRUN]  & ~latch);
      err[ERR_UNDERRUN] <= underrun | (err[ERR_UNDERRUN] & ~latch);
    end
  end

  io_word_counter #(
    .MAX (IN_WORDS),
    .W   (IN_CW)
  ) u_in_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (latch | auto_fire),
    .set     (1'b0),
    .inc     (load_shift & ~auto_fire),
    .dec     (1'b0),
    .cnt     (in_cnt)
  );

  io_word_counter #(
    .MAX (OUT_WORDS),
    .W   (OUT_CW)
  ) u_out_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .set     (latch),
    .inc     (1'b0),
    .dec     (unload_shift & ~latch),
    .cnt     (out_cnt)
  );

  assign in_full   = (in_cnt == IN_CW'(IN_WORDS));
  assign out_empty = (out_cnt == '0);
  assign pin_out   = out_reg[PIN_W-1:0];
  assign pin_oeb   = {PIN_W{we}};

endmodule

// File: tb/tb_io_scan_bridge.sv
// Bench for io_scan_bridge: two instances (manual and auto latch) against a word-queue model.
module tb_io_scan_bridge;

  localparam int NW = 5;
  localparam logic [133:0] LIT1   = 134'h01_00000002_00000003_00000004_00000005;
  localparam logic [133:0] LIT3   = 134'h02_00000003_00000004_00000005_00000006;
  localparam logic [133:0] LIT4   = 134'h05_00000006_00000007_00000008_00000009;
  localparam logic [133:0] LIT5   = 134'h11_00000012_00000013_00000014_00000015;
  localparam logic [147:0] LIT_CO = 148'h12345_6789abcd_ef012345_6789abcd_deadbeef;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         we;
  logic         shift;
  logic         latch;
  logic [31:0]  pin_in;
  logic [147:0] core_out;

  logic [31:0]  pin_out    [2];
  logic [31:0]  pin_oeb    [2];
  logic [133:0] core_in    [2];
  logic         in_full    [2];
  logic         out_empty  [2];
  logic         latch_done [2];
  logic [1:0]   err        [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  io_scan_bridge #(.PIN_W(32), .IN_W(134), .OUT_W(148), .AUTO_LATCH(0)) u_man (
    .clk(clk), .reset_n(reset_n), .we(we), .shift(shift), .latch(latch),
    .pin_in(pin_in), .pin_out(pin_out[0]), .pin_oeb(pin_oeb[0]),
    .core_in(core_in[0]), .core_out(core_out), .in_full(in_full[0]),
    .out_empty(out_empty[0]), .latch_done(latch_done[0]), .err(err[0])
  );

  io_scan_bridge #(.PIN_W(32), .IN_W(134), .OUT_W(148), .AUTO_LATCH(1)) u_auto (
    .clk(clk), .reset_n(reset_n), .we(we), .shift(shift), .latch(latch),
    .pin_in(pin_in), .pin_out(pin_out[1]), .pin_oeb(pin_oeb[1]),
    .core_in(core_in[1]), .core_out(core_out), .in_full(in_full[1]),
    .out_empty(out_empty[1]), .latch_done(latch_done[1]), .err(err[1])
  );

  // Model: last NW loaded words (index 0 newest), NW unload words (index 0 on the pads).
  logic [31:0]  m_in   [2][NW];
  logic [31:0]  m_out  [2][NW];
  int           m_in_cnt  [2];
  int           m_out_cnt [2];
  logic [133:0] m_core [2];
  logic [1:0]   m_err  [2];
  logic         m_ld   [2];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [159:0] in_vec(input int a);
    logic [159:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[k*32 +: 32] = m_in[a][k];
    return v;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      for (int k = 0; k < NW; k++) begin
        m_in[a][k]  = '0;
        m_out[a][k] = '0;
      end
      m_in_cnt[a]  = 0;
      m_out_cnt[a] = 0;
      m_core[a]    = '0;
      m_err[a]     = '0;
      m_ld[a]      = 1'b0;
    end
  endtask

  task automatic model_step(input int a, input bit auto_mode);
    logic [159:0] pre, post, co;
    logic sw, sr, fire, ovr, und;
    sw   = shift && we;
    sr   = shift && !we;
    pre  = in_vec(a);
    fire = auto_mode && sw && (m_in_cnt[a] == NW - 1);
    ovr  = sw && (m_in_cnt[a] == NW) && !auto_mode;
    und  = sr && (m_out_cnt[a] == 0);
    if (sw) begin
      for (int k = NW - 1; k > 0; k--) m_in[a][k] = m_in[a][k-1];
      m_in[a][0] = pin_in;
    end
    post = in_vec(a);
    if (fire) begin
      m_core[a]   = post[133:0];
      m_in_cnt[a] = 0;
    end else if (latch) begin
      m_core[a]   = pre[133:0];
      m_in_cnt[a] = sw ? 1 : 0;
    end else if (sw && m_in_cnt[a] < NW) begin
      m_in_cnt[a]++;
    end
    m_err[a][0] = ovr ? 1'b1 : (latch ? 1'b0 : m_err[a][0]);
    m_err[a][1] = und ? 1'b1 : (latch ? 1'b0 : m_err[a][1]);
    if (latch) begin
      co = {12'b0, core_out};
      for (int k = 0; k < NW; k++) m_out[a][k] = co[k*32 +: 32];
      m_out_cnt[a] = NW;
    end else if (sr) begin
      for (int k = 0; k < NW - 1; k++) m_out[a][k] = m_out[a][k+1];
      m_out[a][NW-1] = '0;
      if (m_out_cnt[a] > 0) m_out_cnt[a]--;
    end
    m_ld[a] = latch || fire;
  endtask

  // Outputs checked mid-cycle; the model then advances using the inputs the next edge will see.
  always @(negedge clk) begin
    if (!reset_n) model_reset();
    for (int a = 0; a < 2; a++) begin
      chk($sformatf("core_in[%0d]", a),    core_in[a],    m_core[a]);
      chk($sformatf("pin_out[%0d]", a),    pin_out[a],    m_out[a][0]);
      chk($sformatf("pin_oeb[%0d]", a),    pin_oeb[a],    {32{we}});
      chk($sformatf("in_full[%0d]", a),    in_full[a],    m_in_cnt[a] == NW);
      chk($sformatf("out_empty[%0d]", a),  out_empty[a],  m_out_cnt[a] == 0);
      chk($sformatf("latch_done[%0d]", a), latch_done[a], m_ld[a]);
      chk($sformatf("err[%0d]", a),        err[a],        m_err[a]);
    end
    if (reset_n) begin
      model_step(0, 1'b0);
      model_step(1, 1'b1);
    end
  end

  task automatic cyc(input logic w, input logic s, input logic l, input logic [31:0] d);
    we     = w;
    shift  = s;
    latch  = l;
    pin_in = d;
    @(posedge clk);
    #1;
    shift = 1'b0;
    latch = 1'b0;
  endtask

  logic [31:0]  exp_w [NW+1];
  logic [159:0] rnd;

  initial begin
    model_reset();
    reset_n  = 1'b0;
    we       = 1'b1;
    shift    = 1'b0;
    latch    = 1'b0;
    pin_in   = '0;
    core_out = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    chk("rst_core_in",   core_in[0],    134'h0);
    chk("rst_in_full",   in_full[0],    1'b0);
    chk("rst_out_empty", out_empty[0],  1'b1);
    chk("rst_pin_out",   pin_out[0],    32'h0);
    chk("rst_err",       err[0],        2'b00);
    chk("rst_latch_dn",  latch_done[0], 1'b0);
    chk("rst_pin_oeb",   pin_oeb[0],    32'hffff_ffff);

    // Load 1..5 then latch
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 1'b0, 32'(i));
    chk("auto_core_in",  core_in[1], LIT1);
    chk("auto_in_full",  in_full[1], 1'b0);
    chk("man_hold",      core_in[0], 134'h0);
    chk("man_in_full",   in_full[0], 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    chk("latch_core_in", core_in[0], LIT1);
    chk("latch_done_hi", latch_done[0], 1'b1);
    chk("latch_in_full", in_full[0], 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("latch_done_lo", latch_done[0], 1'b0);

    // Capture core_out and unload it
    core_out = LIT_CO;
    exp_w[0] = 32'hdeadbeef;
    exp_w[1] = 32'h6789abcd;
    exp_w[2] = 32'hef012345;
    exp_w[3] = 32'h6789abcd;
    exp_w[4] = 32'h00012345;
    exp_w[5] = 32'h0;
    cyc(1'b0, 1'b0, 1'b1, 32'h0);
    chk("unl_oeb",  pin_oeb[0], 32'h0);
    chk("unl_w0",   pin_out[0], exp_w[0]);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      chk($sformatf("unl_w%0d", i), pin_out[0], exp_w[i]);
      chk($sformatf("unl_empty%0d", i), out_empty[0], i == 5);
    end
    chk("unl_no_err", err[0], 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("underrun", err[0], 2'b10);

    // Overrun: six words into a five-word register
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    chk("err_cleared", err[0], 2'b00);
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'(i));
      chk($sformatf("ovr_err%0d", i), err[0], (i == 6) ? 2'b01 : 2'b00);
    end
    chk("auto_no_ovr", err[1], 2'b00);
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    chk("ovr_core_in", core_in[0], LIT3);
    chk("ovr_clear",   err[0], 2'b00);

    // Latch together with a load shift
    for (int i = 7; i <= 9; i++) cyc(1'b1, 1'b1, 1'b0, 32'(i));
    cyc(1'b1, 1'b1, 1'b1, 32'hA);
    chk("ls_core_in", core_in[0], LIT4);
    chk("ls_in_full", in_full[0], 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'(10 + i));
      chk($sformatf("ls_full%0d", i), in_full[0], i == 4);
    end

    // Reset in the middle of a transfer
    core_out = LIT_CO;
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b1, 1'b0, 32'h20 + 32'(i));
    chk("pre_rst_pin", pin_out[0], 32'hdeadbeef);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_core_in", core_in[0],   134'h0);
    chk("mid_rst_pin_out", pin_out[0],   32'h0);
    chk("mid_rst_empty",   out_empty[0], 1'b1);
    chk("mid_rst_full",    in_full[0],   1'b0);
    chk("mid_rst_err",     err[0],       2'b00);
    chk("mid_rst_ld",      latch_done[0], 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 1'b0, 32'h10 + 32'(i));
    cyc(1'b1, 1'b0, 1'b1, 32'h0);
    chk("post_rst_core_in", core_in[0], LIT5);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) begin
        rnd      = {$urandom, $urandom, $urandom, $urandom, $urandom};
        core_out = rnd[147:0];
      end
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 8, $urandom);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
